// File: rtl/char_input_arbiter.sv
// Host/stream character arbiter for the OSD character buffer: round-robin grant,
// per-character holdoff pacing, clear-screen sequencing and frame-read strobes.
// Optional FRAME_LOCK_EN: a frame-read strobe locks out chars/clears until i_frame_done.
//
// state      | meaning
// IDLE       | waiting; a pending clear beats any valid character
// ISSUE      | strobing the captured character into the buffer
// HOLD       | character holdoff countdown
// CLEAR_HOLD | clear-screen holdoff countdown
module char_input_arbiter #(
    parameter int CONSOLE_DEPTH    = 12,
    parameter int CHAR_IMAGE_WIDTH = 80,
    parameter int NORMAL_HOLDOFF   = 3,
    parameter int TAB_HOLDOFF      = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_host_valid,
    output logic       o_host_ready,
    input  logic [7:0] i_host_char,
    input  logic       i_host_alt,
    input  logic       i_strm_valid,
    output logic       o_strm_ready,
    input  logic [7:0] i_strm_char,
    input  logic       i_strm_alt,
    input  logic       i_clear_stb,
    input  logic       i_frame_start_stb,
    input  logic       i_frame_done,
    output logic       o_char_stb,
    output logic [7:0] o_char,
    output logic       o_alt_func_en,
    output logic       o_clear_screen_stb,
    output logic       o_read_frame_stb,
    output logic       o_busy
);
    localparam int CNT_W         = CONSOLE_DEPTH + 1;
    localparam int CLEAR_HOLDOFF = (1 << CONSOLE_DEPTH) + 4;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, CLEAR_HOLD} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] char_holdoff;
    logic             clear_pending, clear_pending_nx;
    logic             last_grant, last_grant_nx;
    logic [7:0]       cap_char, cap_char_nx;
    logic             cap_alt, cap_alt_nx;
    logic             grant_strm;
    logic             host_ready_nx, strm_ready_nx, char_stb_nx, clear_stb_nx;
    logic             frame_lock, frame_lock_nx, read_frame_nx;

    // last_grant = 1 means the stream was served last, so the host wins a tie
    assign grant_strm = i_strm_valid && (!i_host_valid || !last_grant);

    always_comb begin
        char_holdoff = CNT_W'(NORMAL_HOLDOFF);
        if (!cap_alt) begin
            if (cap_char == 8'h0D || cap_char == 8'h0A)
                char_holdoff = CNT_W'(CHAR_IMAGE_WIDTH + 2);
            else if (cap_char == 8'h09)
                char_holdoff = CNT_W'(TAB_HOLDOFF);
        end
    end

    always_comb begin
        state_nx         = state;
        cnt_nx           = cnt;
        clear_pending_nx = clear_pending | i_clear_stb;
        last_grant_nx    = last_grant;
        cap_char_nx      = cap_char;
        cap_alt_nx       = cap_alt;
        host_ready_nx    = 1'b0;
        strm_ready_nx    = 1'b0;
        char_stb_nx      = 1'b0;
        clear_stb_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (!frame_lock) begin
                    // a clear arriving this very cycle still beats a waiting char
                    if (clear_pending || i_clear_stb) begin
                        clear_stb_nx     = 1'b1;
                        clear_pending_nx = 1'b0;
                        cnt_nx           = CNT_W'(CLEAR_HOLDOFF);
                        state_nx         = CLEAR_HOLD;
                    end else if (i_host_valid || i_strm_valid) begin
                        last_grant_nx = grant_strm;
                        host_ready_nx = !grant_strm;
                        strm_ready_nx = grant_strm;
                        cap_char_nx   = grant_strm ? i_strm_char : i_host_char;
                        cap_alt_nx    = grant_strm ? i_strm_alt  : i_host_alt;
                        state_nx      = ISSUE;
                    end
                end
            end
            ISSUE: begin
                char_stb_nx = 1'b1;
                cnt_nx      = char_holdoff;
                state_nx    = HOLD;
            end
            HOLD, CLEAR_HOLD: begin
                if (cnt <= CNT_W'(1)) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef FRAME_LOCK_EN
    // a done in the same cycle as a start unlocks first, so the new frame re-locks
    always_comb begin
        read_frame_nx = i_frame_start_stb && (!frame_lock || i_frame_done);
        frame_lock_nx = frame_lock;
        if (i_frame_done)
            frame_lock_nx = 1'b0;
        if (read_frame_nx)
            frame_lock_nx = 1'b1;
    end
`else
    logic frame_done_unused;
    assign frame_done_unused = i_frame_done;
    assign read_frame_nx     = i_frame_start_stb;
    assign frame_lock_nx     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            cnt                <= '0;
            clear_pending      <= 1'b0;
            last_grant         <= 1'b1;
            cap_char           <= '0;
            cap_alt            <= 1'b0;
            frame_lock         <= 1'b0;
            o_host_ready       <= 1'b0;
            o_strm_ready       <= 1'b0;
            o_char_stb         <= 1'b0;
            o_char             <= '0;
            o_alt_func_en      <= 1'b0;
            o_clear_screen_stb <= 1'b0;
            o_read_frame_stb   <= 1'b0;
        end else begin
            state              <= state_nx;
            cnt                <= cnt_nx;
            clear_pending      <= clear_pending_nx;
            last_grant         <= last_grant_nx;
            cap_char           <= cap_char_nx;
            cap_alt            <= cap_alt_nx;
            frame_lock         <= frame_lock_nx;
            o_host_ready       <= host_ready_nx;
            o_strm_ready       <= strm_ready_nx;
            o_char_stb         <= char_stb_nx;
            o_clear_screen_stb <= clear_stb_nx;
            o_read_frame_stb   <= read_frame_nx;
            if (char_stb_nx) begin
                o_char        <= cap_char;
                o_alt_func_en <= cap_alt;
            end
        end
    end

    assign o_busy = (state != IDLE) || clear_pending;

endmodule

// File: tb/tb_char_input_arbiter.sv
// Bench for char_input_arbiter: holdoff table, hand-written corner sequences and a
// randomized two-source run checked against a transaction-level timing model.
`timescale 1ns/1ps
module tb_char_input_arbiter;
    localparam int CONSOLE_DEPTH    = 12;
    localparam int CHAR_IMAGE_WIDTH = 80;
    localparam int NORMAL_HOLDOFF   = 3;
    localparam int TAB_HOLDOFF      = 10;
    localparam int CLEAR_HOLDOFF    = (1 << CONSOLE_DEPTH) + 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_host_valid, o_host_ready, i_host_alt;
    logic [7:0] i_host_char;
    logic       i_strm_valid, o_strm_ready, i_strm_alt;
    logic [7:0] i_strm_char;
    logic       i_clear_stb, i_frame_start_stb, i_frame_done;
    logic       o_char_stb, o_alt_func_en, o_clear_screen_stb, o_read_frame_stb, o_busy;
    logic [7:0] o_char;

    char_input_arbiter #(
        .CONSOLE_DEPTH(CONSOLE_DEPTH), .CHAR_IMAGE_WIDTH(CHAR_IMAGE_WIDTH),
        .NORMAL_HOLDOFF(NORMAL_HOLDOFF), .TAB_HOLDOFF(TAB_HOLDOFF)
    ) dut (
        .clk(clk), .rst(rst),
        .i_host_valid(i_host_valid), .o_host_ready(o_host_ready),
        .i_host_char(i_host_char), .i_host_alt(i_host_alt),
        .i_strm_valid(i_strm_valid), .o_strm_ready(o_strm_ready),
        .i_strm_char(i_strm_char), .i_strm_alt(i_strm_alt),
        .i_clear_stb(i_clear_stb), .i_frame_start_stb(i_frame_start_stb),
        .i_frame_done(i_frame_done),
        .o_char_stb(o_char_stb), .o_char(o_char), .o_alt_func_en(o_alt_func_en),
        .o_clear_screen_stb(o_clear_screen_stb), .o_read_frame_stb(o_read_frame_stb),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event never arrived within its cycle budget (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int holdoff_of(input logic [7:0] c, input logic alt);
        if (!alt && (c == 8'h0D || c == 8'h0A)) return CHAR_IMAGE_WIDTH + 2;
        if (!alt && c == 8'h09) return TAB_HOLDOFF;
        return NORMAL_HOLDOFF;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        i_host_valid = 0; i_host_char = 0; i_host_alt = 0;
        i_strm_valid = 0; i_strm_char = 0; i_strm_alt = 0;
        i_clear_stb = 0; i_frame_start_stb = 0; i_frame_done = 0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic wait_ready(input bit strm, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (strm ? o_strm_ready : o_host_ready) begin
                at = cyc;
                return;
            end
        end
        timeout(strm ? "wait_strm_ready" : "wait_host_ready");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 6000; i++) begin
            if (!o_busy) return;
            tick();
        end
        timeout("wait_idle");
    endtask

    typedef struct {
        logic [7:0] ch;
        logic       alt;
        int         gap;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int t1, t2, m, busy_cnt, nacc;
        bit got_r, got_f, early;
        logic [7:0] got_q[$];
        logic [7:0] exp_hs[4];
        // random-section model state
        int last_ready, last_h;
        bit last_g, dh, ds, fs_prev, ready_prev, due, hr, sr;
        logic [8:0] expq[$];
        logic [8:0] last_out, w;

        // ready-to-next-ready spacing = 2 + holdoff of the first char
        tbl[0] = '{8'h41, 1'b0, 5};
        tbl[1] = '{8'h0D, 1'b0, 84};
        tbl[2] = '{8'h0A, 1'b0, 84};
        tbl[3] = '{8'h09, 1'b0, 12};
        tbl[4] = '{8'h09, 1'b1, 5};
        tbl[5] = '{8'h0D, 1'b1, 5};
        tbl[6] = '{8'h08, 1'b0, 5};
        tbl[7] = '{8'h00, 1'b0, 5};
        tbl[8] = '{8'hFF, 1'b1, 5};

        do_reset();
        tick();
        check("reset_host_ready", o_host_ready, 0);
        check("reset_strm_ready", o_strm_ready, 0);
        check("reset_char_stb", o_char_stb, 0);
        check("reset_char", {o_alt_func_en, o_char}, 9'h000);
        check("reset_clear_stb", o_clear_screen_stb, 0);
        check("reset_read_frame", o_read_frame_stb, 0);
        check("reset_busy", o_busy, 0);

        // holdoff table on the host path
        for (int i = 0; i < 9; i++) begin
            i_host_char = tbl[i].ch; i_host_alt = tbl[i].alt; i_host_valid = 1;
            wait_ready(0, 200, t1);
            i_host_valid = 0;
            tick();
            check("tbl_stb", o_char_stb, 1);
            check("tbl_char", {o_alt_func_en, o_char}, {tbl[i].alt, tbl[i].ch});
            i_host_char = 8'h61; i_host_alt = 0; i_host_valid = 1;
            wait_ready(0, 200, t2);
            i_host_valid = 0;
            check("tbl_gap", t2 - t1, tbl[i].gap);
            wait_idle();
        end

        // both sources continuously valid: H,S,H,S
        do_reset();
        exp_hs = '{8'h48, 8'h53, 8'h48, 8'h53};
        i_host_char = 8'h48; i_strm_char = 8'h53;
        i_host_valid = 1; i_strm_valid = 1;
        got_q.delete();
        for (int i = 0; i < 100 && got_q.size() < 4; i++) begin
            tick();
            if (o_char_stb) got_q.push_back(o_char);
        end
        i_host_valid = 0; i_strm_valid = 0;
        if (got_q.size() < 4) timeout("rr_four_strobes");
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            check("rr_order", got_q[i], exp_hs[i]);
        wait_idle();

        // clear together with a host char: clear first, busy for the clear holdoff
        do_reset();
        i_clear_stb = 1; i_host_char = 8'h43; i_host_valid = 1;
        tick();
        i_clear_stb = 0;
        check("clr_stb", o_clear_screen_stb, 1);
        check("clr_host_waits", o_host_ready, 0);
        busy_cnt = 0; early = 0;
        while (o_busy && busy_cnt < 5000) begin
            busy_cnt++;
            tick();
            if (o_host_ready || o_char_stb) early = 1;
        end
        check("clr_busy_len", busy_cnt, CLEAR_HOLDOFF);
        check("clr_no_early_char", early, 0);
        tick();
        check("clr_then_ready", o_host_ready, 1);
        i_host_valid = 0;
        tick();
        check("clr_then_char", {o_char_stb, o_char}, {1'b1, 8'h43});
        wait_idle();

        // frame-read strobes
        do_reset();
`ifdef FRAME_LOCK_EN
        i_frame_start_stb = 1;
        tick();
        i_frame_start_stb = 0;
        check("lock_frame_stb", o_read_frame_stb, 1);
        i_host_char = 8'h4C; i_host_valid = 1;
        got_r = 0; got_f = 0;
        for (int i = 0; i < 20; i++) begin
            i_frame_start_stb = (i == 5);
            tick();
            if (o_host_ready) got_r = 1;
            if (o_read_frame_stb) got_f = 1;
        end
        i_frame_start_stb = 0;
        check("lock_no_ready", got_r, 0);
        check("lock_no_frame_stb", got_f, 0);
        i_frame_done = 1; m = cyc;
        tick();
        i_frame_done = 0;
        check("lock_done_no_stb", o_read_frame_stb, 0);
        wait_ready(0, 10, t1);
        check("lock_release_latency", t1 - m, 2);
        i_host_valid = 0;
        wait_idle();
        i_frame_start_stb = 1;
        tick();
        i_frame_done = 1;
        tick();
        i_frame_start_stb = 0; i_frame_done = 0;
        check("lock_done_start_relock", o_read_frame_stb, 1);
        i_host_valid = 1; got_r = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_host_ready) got_r = 1;
        end
        check("lock_relocked_no_ready", got_r, 0);
        i_frame_done = 1;
        tick();
        i_frame_done = 0;
        wait_ready(0, 10, t1);
        i_host_valid = 0;
        wait_idle();
`else
        i_frame_start_stb = 1;
        tick();
        i_frame_start_stb = 0;
        check("frame_stb", o_read_frame_stb, 1);
        tick();
        check("frame_stb_pulse", o_read_frame_stb, 0);
        i_frame_done = 1; i_frame_start_stb = 1;
        tick();
        i_frame_done = 0; i_frame_start_stb = 0;
        check("frame_stb_again", o_read_frame_stb, 1);
`endif

        // reset mid CR holdoff with a pending clear
        do_reset();
        i_host_char = 8'h0D; i_host_valid = 1;
        wait_ready(0, 20, t1);
        i_host_valid = 0;
        repeat (6) tick();
        i_clear_stb = 1;
        tick();
        i_clear_stb = 0;
        check("rstmid_busy", o_busy, 1);
        rst = 1; i_host_char = 8'h78; i_host_valid = 1;
        tick();
        check("rstmid_busy_low", o_busy, 0);
        check("rstmid_no_stb", {o_char_stb, o_clear_screen_stb, o_host_ready}, 3'b000);
        rst = 0;
        tick();
        check("rstmid_ready", o_host_ready, 1);
        check("rstmid_clear_dropped", o_clear_screen_stb, 0);
        i_host_valid = 0;
        tick();
        check("rstmid_char", {o_char_stb, o_char}, {1'b1, 8'h78});
        wait_idle();
        check("rstmid_no_late_clear", o_clear_screen_stb, 0);

        // randomized two-source run
        do_reset();
        last_ready = -1000; last_h = 0; last_g = 1;
        dh = 0; ds = 0; fs_prev = 0; ready_prev = 0; last_out = 9'h000;
        nacc = 0;
        expq.delete();
        for (int k = 0; k < 9000 && nacc < 150; k++) begin
            tick();
            hr = o_host_ready; sr = o_strm_ready;
            due = (dh || ds) && (cyc >= last_ready + 2 + last_h);
            check("rnd_ready_timing", hr | sr, due);
            check("rnd_read_frame", o_read_frame_stb, fs_prev);
            check("rnd_no_clear", o_clear_screen_stb, 0);
            if (hr || sr) begin
                check("rnd_one_ready", hr & sr, 0);
                if (dh && ds) check("rnd_round_robin", sr, !last_g);
                else          check("rnd_single_grant", sr, ds);
                w = sr ? {i_strm_alt, i_strm_char} : {i_host_alt, i_host_char};
                expq.push_back(w);
                last_ready = cyc; last_h = holdoff_of(w[7:0], w[8]); last_g = sr;
                nacc++;
            end
            check("rnd_stb_after_ready", o_char_stb, ready_prev);
            if (o_char_stb && expq.size() > 0) begin
                w = expq.pop_front();
                check("rnd_char", {o_alt_func_en, o_char}, w);
                last_out = w;
            end else if (!o_char_stb) begin
                check("rnd_char_hold", {o_alt_func_en, o_char}, last_out);
            end
            ready_prev = hr | sr;

            if (hr) i_host_valid = 0;
            else if (i_host_valid && $urandom_range(0, 24) == 0) i_host_valid = 0;
            else if (!i_host_valid && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 7))
                    0: i_host_char = 8'h0D;
                    1: i_host_char = 8'h0A;
                    2: i_host_char = 8'h09;
                    default: i_host_char = 8'($urandom);
                endcase
                i_host_alt = ($urandom_range(0, 3) == 0);
                i_host_valid = 1;
            end
            if (sr) i_strm_valid = 0;
            else if (i_strm_valid && $urandom_range(0, 24) == 0) i_strm_valid = 0;
            else if (!i_strm_valid && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 7))
                    0: i_strm_char = 8'h0D;
                    1: i_strm_char = 8'h0A;
                    2: i_strm_char = 8'h09;
                    default: i_strm_char = 8'($urandom);
                endcase
                i_strm_alt = ($urandom_range(0, 3) == 0);
                i_strm_valid = 1;
            end
`ifndef FRAME_LOCK_EN
            i_frame_start_stb = ($urandom_range(0, 9) == 0);
`endif
            dh = i_host_valid; ds = i_strm_valid; fs_prev = i_frame_start_stb;
        end
        if (nacc < 150) timeout("rnd_accept_count");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
